// File: rtl/bullet_ctrl.sv
// Player bullet pool: spawns bullets above the plane on fire, moves them upward
// on each move_tick, retires them at the top of the screen or on hit, and renders them.
module bullet_ctrl #(
  parameter int N_BULLET = 4,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 16,
  parameter int BW       = 4,
  parameter int BH       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                move_tick,
  input  logic                fire,
  input  logic [9:0]          p_x,
  input  logic [9:0]          p_y,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic [N_BULLET-1:0] hit,
  output logic [N_BULLET-1:0] b_active,
  output logic                EN,
  output logic [11:0]         rgb,
  output logic [7:0]          shot_cnt
);

  localparam int unsigned NB = N_BULLET;
  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  logic [9:0]          bx [N_BULLET];
  logic [9:0]          by [N_BULLET];
  logic [CW-1:0]       cooldown;
  logic [N_BULLET-1:0] spawn_sel;
  logic                free_found;
  logic                spawn;
  logic [9:0]          spawn_bx;
  logic [9:0]          spawn_by;

  // Lowest-index free slot, judged on the registered flags so a slot freed by hit
  // this cycle cannot be reused until the next one.
  always_comb begin
    spawn_sel  = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (!b_active[i] && !free_found) begin
        spawn_sel[i] = 1'b1;
        free_found   = 1'b1;
      end
    end
    spawn    = move_tick && fire && (cooldown == '0) && free_found;
    spawn_bx = p_x + 10'(25 - BW / 2);
    spawn_by = (p_y < 10'(BH)) ? '0 : p_y - 10'(BH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_active <= '0;
      cooldown <= '0;
      shot_cnt <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (spawn && spawn_sel[i]) begin
          b_active[i] <= 1'b1;
          bx[i]       <= spawn_bx;
          by[i]       <= spawn_by;
        end else if (b_active[i]) begin
          if (hit[i]) begin
            b_active[i] <= 1'b0;
          end else if (move_tick) begin
            if (by[i] < 10'(SPEED)) b_active[i] <= 1'b0;
            else                    by[i]       <= by[i] - 10'(SPEED);
          end
        end
      end
      if (move_tick) begin
        if (spawn)                 cooldown <= CW'(COOLDOWN);
        else if (cooldown != '0)   cooldown <= cooldown - 1'b1;
      end
      if (spawn) shot_cnt <= shot_cnt + 8'd1;
    end
  end

  // 11-bit compares keep bx+BW / by+BH from wrapping near the screen edge.
  always_comb begin
    EN = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (b_active[i] &&
          ({1'b0, x} >= {1'b0, bx[i]}) && ({1'b0, x} < ({1'b0, bx[i]} + 11'(BW))) &&
          ({1'b0, y} >= {1'b0, by[i]}) && ({1'b0, y} < ({1'b0, by[i]} + 11'(BH))))
        EN = 1'b1;
    end
    rgb = EN ? 12'hF80 : 12'h000;
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl: expectations are queued before each stimulus
// step and popped against DUT outputs once the step has taken effect.
module tb_bullet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_tick;
  logic       fire;
  logic [9:0] p_x, p_y, x, y;
  logic [3:0] hit;
  logic [3:0] b_active;
  logic       EN;
  logic [11:0] rgb;
  logic [7:0] shot_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  bullet_ctrl #(.N_BULLET(4), .SPEED(4), .COOLDOWN(16), .BW(4), .BH(8)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .fire(fire),
    .p_x(p_x), .p_y(p_y), .x(x), .y(y), .hit(hit),
    .b_active(b_active), .EN(EN), .rgb(rgb), .shot_cnt(shot_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock with the given move_tick; hit is a single-cycle pulse.
  task automatic tick(input logic mt);
    move_tick = mt;
    @(posedge clk);
    #1;
    move_tick = 1'b0;
    hit = 4'b0000;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] act, input logic [7:0] cnt);
    push({tag, "_active"}, 32'(act));
    push({tag, "_shots"}, 32'(cnt));
  endtask

  task automatic check_state();
    pop_check(32'(b_active));
    pop_check(32'(shot_cnt));
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic en);
    push({tag, "_en"}, 32'(en));
    push({tag, "_rgb"}, en ? 32'h0F80 : 32'h0000);
    x = 10'(px);
    y = 10'(py);
    #1;
    pop_check(32'(EN));
    pop_check(32'(rgb));
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; move_tick = 1'b0; hit = 4'b0000;
    expect_state("rst", 4'b0000, 8'd0);
    @(posedge clk); #1;
    check_state();
    rst = 1'b0;
    push("post_rst_active", 32'h0);
    @(posedge clk); #1;
    pop_check(32'(b_active));
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; fire = 1'b0; hit = 4'b0000;
    p_x = 10'd295; p_y = 10'd430; x = '0; y = '0;

    // Reset values while held, then first spawn and pixel scan
    @(posedge clk); #1;
    push("rst_hold_active", 32'h0);
    pop_check(32'(b_active));
    probe("rst_hold_pix", 0, 0, 1'b0);
    do_reset();
    fire = 1'b1;
    expect_state("spawn0", 4'b0001, 8'd1);
    tick(1'b1);
    check_state();
    probe("pix_318_422", 318, 422, 1'b1);
    probe("pix_322_422", 322, 422, 1'b0);
    probe("pix_318_430", 318, 430, 1'b0);
    probe("pix_317_425", 317, 425, 1'b0);
    probe("pix_321_429", 321, 429, 1'b1);

    // Cooldown: 16 ticks with fire held produce no spawn
    for (int k = 0; k < 16; k++) begin
      expect_state("cooldown", 4'b0001, 8'd1);
      tick(1'b1);
      check_state();
    end
    probe("slot0_at_358", 318, 358, 1'b1);
    probe("slot0_above_358", 318, 357, 1'b0);
    expect_state("spawn1", 4'b0011, 8'd2);
    tick(1'b1);
    check_state();
    probe("slot0_at_354", 318, 354, 1'b1);
    probe("slot0_above_354", 318, 353, 1'b0);
    probe("slot1_at_422", 318, 422, 1'b1);
    expect_state("cooldown_reloaded", 4'b0011, 8'd2);
    tick(1'b1);
    check_state();

    // Bullet reaching the top retires
    do_reset();
    p_y = 10'd14; fire = 1'b1;
    expect_state("top_spawn", 4'b0001, 8'd1);
    tick(1'b1);
    check_state();
    fire = 1'b0;
    probe("top_by6", 318, 6, 1'b1);
    tick(1'b1);
    probe("top_by2", 318, 2, 1'b1);
    probe("top_above_by2", 318, 1, 1'b0);
    expect_state("top_retire", 4'b0000, 8'd1);
    tick(1'b1);
    check_state();

    // Fill all slots, then full-pool fire, hit/move interaction, hit without tick
    do_reset();
    p_y = 10'd430; fire = 1'b1;
    tick(1'b1);
    for (int s = 1; s < 4; s++) begin
      repeat (16) tick(1'b1);
      expect_state("fill", 4'((1 << (s + 1)) - 1), 8'(s + 1));
      tick(1'b1);
      check_state();
    end
    repeat (16) tick(1'b1);
    expect_state("full_no_spawn", 4'b1111, 8'd4);
    tick(1'b1);
    check_state();
    hit = 4'b0100;
    expect_state("hit_with_move", 4'b1011, 8'd4);
    tick(1'b1);
    check_state();
    expect_state("refill_slot2", 4'b1111, 8'd5);
    tick(1'b1);
    check_state();
    hit = 4'b0001;
    expect_state("hit_no_tick", 4'b1110, 8'd5);
    tick(1'b0);
    check_state();
    hit = 4'b0001;
    expect_state("hit_inactive", 4'b1110, 8'd5);
    tick(1'b0);
    check_state();
    rst = 1'b1;
    expect_state("rst_in_flight", 4'b0000, 8'd0);
    tick(1'b1);
    check_state();
    probe("rst_in_flight_pix", 318, 422, 1'b0);
    rst = 1'b0;

    // Spawn near the top clamps by to 0; shot counter wraps at 256
    do_reset();
    p_y = 10'd3; fire = 1'b1;
    expect_state("clamp_spawn", 4'b0001, 8'd1);
    tick(1'b1);
    check_state();
    probe("clamp_by0", 318, 0, 1'b1);
    probe("clamp_below", 318, 8, 1'b0);
    for (int k = 2; k <= 256; k++) begin
      repeat (16) tick(1'b1);
      expect_state("wrap", 4'b0001, 8'(k));
      tick(1'b1);
      check_state();
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameter N_BULLET, default 4: number of bullet slots (1..8).
REQ-002 Parameter SPEED, default 4: pixels moved upward per move_tick.
REQ-003 Parameter COOLDOWN, default 16: move_ticks between consecutive spawns.
REQ-004 Parameter BW, default 4; BH, default 8: bullet width and height in pixels.
REQ-005 clk  in  1  system clock; only clock in the block.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 move_tick  in  1  single-cycle enable pulse, synchronous to clk, pacing motion.
REQ-008 fire  in  1  level fire request from the key decoder.
REQ-009 p_x, p_y  in  10 each  top-left of the 50x50 plane sprite, from the plane stage.
REQ-010 x, y  in  10 each  current VGA pixel coordinate.
REQ-011 hit  in  N_BULLET  per-slot clear request from collision logic.
REQ-012 b_active  out  N_BULLET  slot-occupied flags.
REQ-013 EN  out  1  current pixel lies inside any active bullet.
REQ-014 rgb  out  12  bullet colour at current pixel.
REQ-015 shot_cnt  out  8  total bullets spawned since reset.

Function
REQ-016 Per slot SHALL hold active, bx[9:0], by[9:0]; all state updates occur on rising clk only.
REQ-017 cooldown counter SHALL decrement by 1 on each move_tick while nonzero and saturate at 0.
REQ-018 Spawn SHALL occur on a cycle with move_tick=1, fire=1, cooldown=0 and at least one slot inactive at start of cycle.
REQ-019 Spawn SHALL fill the lowest-index inactive slot only; one spawn per move_tick maximum.
REQ-020 Spawned bx SHALL be p_x + 25 - BW/2 (23 for defaults); by SHALL be p_y - BH, or 0 if p_y < BH.
REQ-021 Spawn SHALL reload cooldown to COOLDOWN and increment shot_cnt (mod 256, wraps 255->0).
REQ-022 fire with all slots active or cooldown nonzero SHALL be ignored; no queuing.
REQ-023 On move_tick each slot active at start of cycle SHALL: if by < SPEED, go inactive; else by <= by - SPEED; bx unchanged.
REQ-024 A slot spawned this cycle SHALL NOT also move this cycle.
REQ-025 hit[i]=1 SHALL clear slot i active on that cycle regardless of move_tick; hit on an inactive slot has no effect.
REQ-026 hit[i] and move on same cycle: clear wins; slot freed by hit is not available for spawn until next cycle.
REQ-027 EN SHALL be combinational: 1 iff some active slot has bx <= x < bx+BW and by <= y < by+BH, compared at 11-bit width (no wrap).
REQ-028 rgb SHALL be 12'hF80 when EN=1, else 12'h000.
REQ-029 b_active SHALL reflect registered active flags (no combinational path from hit).
REQ-030 move_tick absent: positions and cooldown hold; hit still acts.

Reset
REQ-031 rst=1 at a clk edge SHALL clear all active flags, bx/by to 0, cooldown to 0, shot_cnt to 0; priority over all other inputs including mid-flight bullets.
REQ-032 During and one cycle after reset: b_active=0, EN=0, rgb=12'h000.

Verification
REQ-033 Reset, p_x=295,p_y=430, fire=1, one move_tick -> slot0 active, bx=318, by=422, shot_cnt=1, cooldown=16.
REQ-034 Hold fire, 16 move_ticks -> no second spawn until the 17th tick (cooldown=0 at start), then slot1 spawns; slot0 by=422-64=358 at that point.
REQ-035 Single bullet at by=6, move_tick -> by=2; next move_tick -> inactive, b_active[0]=0.
REQ-036 All 4 slots active, fire=1, cooldown=0, move_tick -> no spawn, shot_cnt unchanged; hit=4'b0100 then next tick -> slot2 refilled.
REQ-037 Pixel scan with slot0 bx=318,by=422: (318,422) EN=1 rgb=F80; (322,422) EN=0; (318,430) EN=0; (317,425) EN=0.
REQ-038 p_y=3 spawn -> by=0; rst asserted with 3 bullets in flight -> next cycle b_active=0, shot_cnt=0.
